// File: rtl/itch_pkg.sv
// Shared ITCH constants: message types, Add Order body layout, side codes,
// and the parser state encoding.
package itch_pkg;

  // Message-type bytes seen by the upstream decoder
  localparam logic [7:0] MSG_TYPE_ADD_ORDER      = 8'h41;  // 'A'
  localparam logic [7:0] MSG_TYPE_ADD_ORDER_MPID = 8'h46;  // 'F'
  localparam logic [7:0] MSG_TYPE_ORDER_DELETE   = 8'h44;  // 'D'

  // Add Order body layout (byte offsets / byte widths)
  localparam int ADD_ORDER_BODY_BYTES = 33;
  localparam int ADD_ORDER_BUF_W      = ADD_ORDER_BODY_BYTES * 8;

  localparam int TS_OFF    = 0;   localparam int TS_BYTES    = 4;
  localparam int OID_OFF   = 4;   localparam int OID_BYTES   = 8;
  localparam int OBID_OFF  = 12;  localparam int OBID_BYTES  = 4;
  localparam int SIDE_OFF  = 16;  localparam int SIDE_BYTES  = 1;
  localparam int OBP_OFF   = 17;  localparam int OBP_BYTES   = 4;
  localparam int QTY_OFF   = 21;  localparam int QTY_BYTES   = 8;
  localparam int PRICE_OFF = 29;  localparam int PRICE_BYTES = 4;

  // Legal side codes
  localparam logic [7:0] SIDE_BUY  = 8'h42;  // 'B'
  localparam logic [7:0] SIDE_SELL = 8'h53;  // 'S'

  typedef enum logic {
    ST_IDLE    = 1'b0,
    ST_COLLECT = 1'b1
  } parser_state_t;

  function automatic logic side_is_valid(input logic [7:0] s);
    return (s == SIDE_BUY) || (s == SIDE_SELL);
  endfunction

endpackage

// File: rtl/itch_byte_accumulator.sv
// Gathers up to 33 body bytes from 64-bit stream words into a flat buffer.
// o_buf_next shows the buffer including the bytes taken this cycle, so the
// parser can register fields in the same cycle the last byte arrives.
module itch_byte_accumulator
  import itch_pkg::*;
(
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       i_restart,   // first word of a new message: write from byte 0
  input  logic                       i_take,      // accept i_n_bytes this cycle
  input  logic [2:0]                 i_src_byte,  // first byte lane of i_data to take
  input  logic [3:0]                 i_n_bytes,   // 0..8 lanes to take
  input  logic [63:0]                i_data,
  output logic [ADD_ORDER_BUF_W-1:0] o_buf_next,
  output logic [5:0]                 o_count,
  output logic                       o_full
);

  logic [ADD_ORDER_BUF_W-1:0] r_buf;
  logic [ADD_ORDER_BUF_W-1:0] w_buf_next;
  logic [5:0]                 r_count;
  logic [5:0]                 w_base;
  logic [5:0]                 w_count_next;
  logic                       r_full;

  // Place the accepted lanes at the current fill position; never past byte 32
  always_comb begin
    w_base       = i_restart ? 6'd0 : r_count;
    w_buf_next   = r_buf;
    w_count_next = r_count;
    if (i_take) begin
      for (int j = 0; j < 8; j++) begin
        if ((j < int'(i_n_bytes)) &&
            ((int'(w_base) + j) < ADD_ORDER_BODY_BYTES) &&
            ((int'(i_src_byte) + j) < 8)) begin
          w_buf_next[(int'(w_base) + j) * 8 +: 8] = i_data[(int'(i_src_byte) + j) * 8 +: 8];
        end
      end
      w_count_next = w_base + {2'b00, i_n_bytes};
    end
  end

  // Buffer, byte count and full flag registers
  always_ff @(posedge clk) begin
    if (rst) begin
      r_buf   <= '0;
      r_count <= 6'd0;
      r_full  <= 1'b0;
    end else begin
      r_buf   <= w_buf_next;
      r_count <= w_count_next;
      r_full  <= (w_count_next == 6'(ADD_ORDER_BODY_BYTES));
    end
  end

  assign o_buf_next = w_buf_next;
  assign o_count    = r_count;
  assign o_full     = r_full;

endmodule

// File: rtl/itch_add_order_parser.sv
// ITCH Add Order body parser. After a start pulse it collects 33 body bytes
// from the word stream, then presents all fields with a one-cycle orderValid.
// Stream handshake: a word is consumed in every cycle where dataValid is high
// (or start is accepted); there is no backpressure, the parser always keeps up.
module itch_add_order_parser
  import itch_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        dataValid,
  input  logic [63:0] dataIn,
  input  logic [5:0]  trackerIn,
  output logic        orderValid,
  output logic [31:0] timestamp,
  output logic [63:0] orderId,
  output logic [31:0] orderBookId,
  output logic [7:0]  side,
  output logic [31:0] orderBookPosition,
  output logic [63:0] quantity,
  output logic [31:0] price,
  output logic [5:0]  trackerOut,
  output logic        busy,
  output logic        protocolError,
  output logic        sideError,
  output logic        stateDbg
);

  parser_state_t r_state;
  logic          r_order_valid, r_busy, r_proto_err, r_side_err;
  logic [31:0]   r_timestamp, r_order_book_id, r_obp, r_price;
  logic [63:0]   r_order_id, r_quantity;
  logic [7:0]    r_side;
  logic [5:0]    r_tracker_out;

  logic [ADD_ORDER_BUF_W-1:0] w_buf_next;
  logic [5:0]                 w_count;
  logic                       w_full;
  logic                       w_start_accept, w_take, w_done;
  logic [5:0]                 w_remaining;
  logic [3:0]                 w_n_bytes;
  logic [2:0]                 w_src_byte;
  logic                       w_unused_tracker_bits;

  // Only byte granularity of the tracker matters
  assign w_unused_tracker_bits = ^trackerIn[2:0];

  // Decide how many lanes of dataIn belong to the message this cycle
  always_comb begin
    w_start_accept = start && (r_state == ST_IDLE);
    w_remaining    = 6'(ADD_ORDER_BODY_BYTES) - w_count;
    w_src_byte     = 3'd0;
    w_n_bytes      = 4'd0;
    w_take         = 1'b0;
    w_done         = 1'b0;
    if (w_start_accept) begin
      w_src_byte = trackerIn[5:3];
      w_n_bytes  = 4'd8 - {1'b0, trackerIn[5:3]};
      w_take     = 1'b1;
    end else if ((r_state == ST_COLLECT) && dataValid && !w_full) begin
      w_n_bytes = (w_remaining >= 6'd8) ? 4'd8 : w_remaining[3:0];
      w_take    = 1'b1;
      w_done    = ({2'b00, w_n_bytes} == w_remaining);
    end
  end

  itch_byte_accumulator u_acc (
    .clk        (clk),
    .rst        (rst),
    .i_restart  (w_start_accept),
    .i_take     (w_take),
    .i_src_byte (w_src_byte),
    .i_n_bytes  (w_n_bytes),
    .i_data     (dataIn),
    .o_buf_next (w_buf_next),
    .o_count    (w_count),
    .o_full     (w_full)
  );

  // Control FSM with registered pulses and field capture on the final byte
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state         <= ST_IDLE;
      r_order_valid   <= 1'b0;
      r_busy          <= 1'b0;
      r_proto_err     <= 1'b0;
      r_side_err      <= 1'b0;
      r_tracker_out   <= 6'd0;
      r_timestamp     <= '0;
      r_order_id      <= '0;
      r_order_book_id <= '0;
      r_side          <= '0;
      r_obp           <= '0;
      r_quantity      <= '0;
      r_price         <= '0;
    end else begin
      r_order_valid <= 1'b0;
      r_side_err    <= 1'b0;
      r_proto_err   <= start && (r_state == ST_COLLECT);
      case (r_state)
        ST_IDLE: begin
          if (w_start_accept) begin
            r_state <= ST_COLLECT;
            r_busy  <= 1'b1;
          end
        end
        ST_COLLECT: begin
          if (w_done) begin
            r_state         <= ST_IDLE;
            r_busy          <= 1'b0;
            r_order_valid   <= 1'b1;
            r_tracker_out   <= {w_n_bytes[2:0], 3'b000};
            r_timestamp     <= w_buf_next[TS_OFF*8    +: TS_BYTES*8];
            r_order_id      <= w_buf_next[OID_OFF*8   +: OID_BYTES*8];
            r_order_book_id <= w_buf_next[OBID_OFF*8  +: OBID_BYTES*8];
            r_side          <= w_buf_next[SIDE_OFF*8  +: SIDE_BYTES*8];
            r_obp           <= w_buf_next[OBP_OFF*8   +: OBP_BYTES*8];
            r_quantity      <= w_buf_next[QTY_OFF*8   +: QTY_BYTES*8];
            r_price         <= w_buf_next[PRICE_OFF*8 +: PRICE_BYTES*8];
            r_side_err      <= !side_is_valid(w_buf_next[SIDE_OFF*8 +: 8]);
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign orderValid        = r_order_valid;
  assign timestamp         = r_timestamp;
  assign orderId           = r_order_id;
  assign orderBookId       = r_order_book_id;
  assign side              = r_side;
  assign orderBookPosition = r_obp;
  assign quantity          = r_quantity;
  assign price             = r_price;
  assign trackerOut        = r_tracker_out;
  assign busy              = r_busy;
  assign protocolError     = r_proto_err;
  assign sideError         = r_side_err;
  assign stateDbg          = r_state;

endmodule

// File: tb/tb_itch_add_order_parser.sv
// Directed bench for the Add Order parser. Body byte i carries value i, with
// the side byte (index 16) overridden per test.
module tb_itch_add_order_parser;

  logic        clk, rst, start, dataValid;
  logic [63:0] dataIn;
  logic [5:0]  trackerIn;
  logic        orderValid, busy, protocolError, sideError, stateDbg;
  logic [31:0] timestamp, orderBookId, orderBookPosition, price;
  logic [63:0] orderId, quantity;
  logic [7:0]  side;
  logic [5:0]  trackerOut;

  int checks = 0;
  int errors = 0;
  logic [7:0] body [33];

  itch_add_order_parser dut (
    .clk(clk), .rst(rst), .start(start), .dataValid(dataValid),
    .dataIn(dataIn), .trackerIn(trackerIn),
    .orderValid(orderValid), .timestamp(timestamp), .orderId(orderId),
    .orderBookId(orderBookId), .side(side),
    .orderBookPosition(orderBookPosition), .quantity(quantity),
    .price(price), .trackerOut(trackerOut), .busy(busy),
    .protocolError(protocolError), .sideError(sideError),
    .stateDbg(stateDbg)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] garbage();
    return {$urandom, $urandom};
  endfunction

  task automatic set_body(input logic [7:0] sd);
    for (int i = 0; i < 33; i++) body[i] = 8'(i);
    body[16] = sd;
  endtask

  // Word whose lane slot0 holds body[p]; lanes outside the body are filler
  function automatic logic [63:0] mk_word(input int slot0, input int p);
    logic [63:0] w;
    for (int k = 0; k < 8; k++) begin
      if (k < slot0)                  w[k*8 +: 8] = 8'hEE;
      else if (p + k - slot0 < 33)    w[k*8 +: 8] = body[p + k - slot0];
      else                            w[k*8 +: 8] = 8'hCC;
    end
    return w;
  endfunction

  // Drivers: inputs change on the falling edge
  task automatic step(input logic st, input logic dv, input logic [63:0] d, input logic [5:0] tr);
    @(negedge clk);
    start = st; dataValid = dv; dataIn = d; trackerIn = tr;
  endtask

  task automatic idle();
    step(1'b0, 1'b0, garbage(), 6'(($urandom_range(0, 63))));
  endtask

  // Start plus continuation words; gaps[w] inserts an invalid cycle before word w+1
  task automatic send_msg(input logic [5:0] tr, input logic [7:0] gaps);
    int p;
    int w;
    step(1'b1, 1'b1, mk_word(int'(tr[5:3]), 0), tr);
    p = 8 - int'(tr[5:3]);
    w = 0;
    while (p < 33) begin
      if (gaps[w]) idle();
      step(1'b0, 1'b1, mk_word(0, p), 6'd0);
      p += 8;
      w++;
    end
  endtask

  // Called one idle cycle after the final word
  task automatic chk_msg(input string tag, input logic [7:0] sd, input logic [5:0] tr_exp, input logic se_exp);
    chk({tag, ".orderValid"}, 64'(orderValid), 64'd1);
    chk({tag, ".timestamp"}, 64'(timestamp), 64'h03020100);
    chk({tag, ".orderId"}, orderId, 64'h0B0A090807060504);
    chk({tag, ".orderBookId"}, 64'(orderBookId), 64'h0F0E0D0C);
    chk({tag, ".side"}, 64'(side), 64'(sd));
    chk({tag, ".orderBookPosition"}, 64'(orderBookPosition), 64'h14131211);
    chk({tag, ".quantity"}, quantity, 64'h1C1B1A1918171615);
    chk({tag, ".price"}, 64'(price), 64'h201F1E1D);
    chk({tag, ".trackerOut"}, 64'(trackerOut), 64'(tr_exp));
    chk({tag, ".sideError"}, 64'(sideError), 64'(se_exp));
    chk({tag, ".busy_done"}, 64'(busy), 64'd0);
    idle();
    chk({tag, ".orderValid_pulse"}, 64'(orderValid), 64'd0);
    chk({tag, ".sideError_pulse"}, 64'(sideError), 64'd0);
    chk({tag, ".price_hold"}, 64'(price), 64'h201F1E1D);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; dataValid = 1'b0; dataIn = '0; trackerIn = '0;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst.orderValid", 64'(orderValid), 64'd0);
    chk("rst.busy", 64'(busy), 64'd0);
    chk("rst.state", 64'(stateDbg), 64'd0);
    chk("rst.timestamp", 64'(timestamp), 64'd0);
    chk("rst.orderId", orderId, 64'd0);
    chk("rst.price", 64'(price), 64'd0);
    chk("rst.trackerOut", 64'(trackerOut), 64'd0);
    chk("rst.protocolError", 64'(protocolError), 64'd0);
    chk("rst.sideError", 64'(sideError), 64'd0);
    rst = 1'b0;
    idle();

    // Tracker 24: 5+8+8+8+4 bytes, ends mid-word at byte 4
    set_body(8'h42);
    send_msg(6'd24, 8'h00);
    chk("t24.pre_valid", 64'(orderValid), 64'd0);
    chk("t24.busy", 64'(busy), 64'd1);
    chk("t24.state", 64'(stateDbg), 64'd1);
    idle();
    chk_msg("t24", 8'h42, 6'd32, 1'b0);

    // Same message with three idle cycles interleaved
    send_msg(6'd24, 8'h07);
    chk("gap.pre_valid", 64'(orderValid), 64'd0);
    chk("gap.busy", 64'(busy), 64'd1);
    idle();
    chk_msg("gap", 8'h42, 6'd32, 1'b0);

    // Tracker 0: 8*4+1 bytes; side 0x10 is illegal
    set_body(8'h10);
    send_msg(6'd0, 8'h00);
    chk("t0.pre_valid", 64'(orderValid), 64'd0);
    idle();
    chk_msg("t0", 8'h10, 6'd8, 1'b1);

    // Tracker 63 (lane 7): 1+8*4 bytes ends on a word boundary; side 'A' illegal
    set_body(8'h41);
    send_msg(6'd63, 8'h00);
    idle();
    chk_msg("t63", 8'h41, 6'd0, 1'b1);

    // Second start during collection is dropped and flagged
    set_body(8'h53);
    step(1'b1, 1'b1, mk_word(0, 0), 6'd0);
    step(1'b0, 1'b1, mk_word(0, 8), 6'd0);
    step(1'b1, 1'b1, mk_word(0, 16), 6'd16);
    chk("proto.err_early", 64'(protocolError), 64'd0);
    step(1'b0, 1'b1, mk_word(0, 24), 6'd0);
    chk("proto.err_pulse", 64'(protocolError), 64'd1);
    step(1'b0, 1'b1, mk_word(0, 32), 6'd0);
    chk("proto.err_clear", 64'(protocolError), 64'd0);
    chk("proto.pre_valid", 64'(orderValid), 64'd0);
    idle();
    chk_msg("proto", 8'h53, 6'd8, 1'b0);
    chk("proto.second_dropped", 64'(busy), 64'd0);

    // Reset after two words discards the partial message
    step(1'b1, 1'b1, mk_word(0, 0), 6'd0);
    step(1'b0, 1'b1, mk_word(0, 8), 6'd0);
    step(1'b0, 1'b1, mk_word(0, 16), 6'd0);
    @(negedge clk);
    rst = 1'b1; start = 1'b0; dataValid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst.busy", 64'(busy), 64'd0);
    chk("midrst.orderValid", 64'(orderValid), 64'd0);
    chk("midrst.price", 64'(price), 64'd0);

    // Reset wins over a simultaneous start
    @(negedge clk);
    rst = 1'b1; start = 1'b1; dataValid = 1'b1; dataIn = mk_word(0, 0); trackerIn = 6'd0;
    @(negedge clk);
    rst = 1'b0; start = 1'b0; dataValid = 1'b0;
    chk("rststart.busy", 64'(busy), 64'd0);
    chk("rststart.state", 64'(stateDbg), 64'd0);
    repeat (3) idle();
    chk("rststart.no_valid", 64'(orderValid), 64'd0);

    // Clean message after reset, legal sell side
    send_msg(6'd0, 8'h00);
    idle();
    chk_msg("post_rst", 8'h53, 6'd8, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
